// File: rtl/control_stage.sv
// control_stage: ID-stage control decoder with a registered ID/EX control bundle.
// Handles stall/flush, squashes a configurable number of instructions after a
// jump, flags unknown opcodes, and runs a halt -> drain -> halted sequence.
module control_stage #(
    parameter int                  NB_DATA      = 32,
    parameter int                  NB_OPCODE    = 6,
    parameter int                  NB_FUNCTION  = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111,
    parameter int                  DRAIN_CYCLES = 4,
    parameter int                  N_SQUASH     = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_instruction,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [1:0]           o_alu_op,
    output logic                 o_alu_src,
    output logic                 o_reg_dst,
    output logic                 o_branch,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_mem_to_reg,
    output logic                 o_reg_write,
    output logic [1:0]           o_jump,
    output logic                 o_flush,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic                 o_illegal,
    output logic                 o_halted
);

    // Drain counter must hold DRAIN_CYCLES-1.
    localparam int NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [NB_OPCODE-1:0] OP_RTYPE = NB_OPCODE'(6'b000000);
    localparam logic [NB_OPCODE-1:0] OP_J     = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_JAL   = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_BEQ   = NB_OPCODE'(6'b000100);
    localparam logic [NB_OPCODE-1:0] OP_BNE   = NB_OPCODE'(6'b000101);
    localparam logic [NB_OPCODE-1:0] OP_ADDI  = NB_OPCODE'(6'b001000);
    localparam logic [NB_OPCODE-1:0] OP_SLTI  = NB_OPCODE'(6'b001010);
    localparam logic [NB_OPCODE-1:0] OP_ANDI  = NB_OPCODE'(6'b001100);
    localparam logic [NB_OPCODE-1:0] OP_ORI   = NB_OPCODE'(6'b001101);
    localparam logic [NB_OPCODE-1:0] OP_XORI  = NB_OPCODE'(6'b001110);
    localparam logic [NB_OPCODE-1:0] OP_LUI   = NB_OPCODE'(6'b001111);
    localparam logic [NB_OPCODE-1:0] OP_LB    = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_LH    = NB_OPCODE'(6'b100001);
    localparam logic [NB_OPCODE-1:0] OP_LW    = NB_OPCODE'(6'b100011);
    localparam logic [NB_OPCODE-1:0] OP_LBU   = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_LHU   = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_LWU   = NB_OPCODE'(6'b100111);
    localparam logic [NB_OPCODE-1:0] OP_SB    = NB_OPCODE'(6'b101000);
    localparam logic [NB_OPCODE-1:0] OP_SH    = NB_OPCODE'(6'b101001);
    localparam logic [NB_OPCODE-1:0] OP_SW    = NB_OPCODE'(6'b101011);

    localparam logic [NB_FUNCTION-1:0] FN_JR   = NB_FUNCTION'(6'b001000);
    localparam logic [NB_FUNCTION-1:0] FN_JALR = NB_FUNCTION'(6'b001001);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [1:0]           alu_op;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 branch;
        logic                 mem_read;
        logic                 mem_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic [1:0]           jump;
        logic                 flush;
        logic [NB_OPCODE-1:0] opcode;
        logic                 illegal;
    } bundle_t;

    state_t               state_reg,  state_next;
    bundle_t              bundle_reg, bundle_next;
    bundle_t              dec_bundle;
    logic                 dec_halt;
    logic [1:0]           squash_reg, squash_next;
    logic [NB_DRAIN-1:0]  drain_reg,  drain_next;
    logic                 halted_reg, halted_next;

    logic [NB_OPCODE-1:0]   instr_opcode;
    logic [NB_FUNCTION-1:0] instr_funct;
    logic                   unused_instr_bits;

    assign instr_opcode      = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign instr_funct       = i_instruction[NB_FUNCTION-1:0];
    // Register/immediate fields are consumed by other stages, not here.
    assign unused_instr_bits = ^i_instruction[NB_DATA-NB_OPCODE-1:NB_FUNCTION];

    // Pure decode of the presented instruction; unknown opcodes yield a bubble
    // with only the illegal flag set.
    always_comb begin
        dec_bundle = '0;
        dec_halt   = 1'b0;
        if (instr_opcode == HALT_OPCODE) begin
            dec_halt = 1'b1;
        end else begin
            case (instr_opcode)
                OP_RTYPE: begin
                    dec_bundle.valid  = 1'b1;
                    dec_bundle.opcode = NB_OPCODE'(instr_funct);
                    if (instr_funct == FN_JALR) begin
                        dec_bundle.reg_dst   = 1'b1;
                        dec_bundle.reg_write = 1'b1;
                        dec_bundle.jump      = 2'b10;
                        dec_bundle.flush     = 1'b1;
                    end else if (instr_funct == FN_JR) begin
                        dec_bundle.jump  = 2'b11;
                        dec_bundle.flush = 1'b1;
                    end else begin
                        dec_bundle.reg_dst   = 1'b1;
                        dec_bundle.alu_op    = 2'b10;
                        dec_bundle.reg_write = 1'b1;
                    end
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
                    dec_bundle.valid     = 1'b1;
                    dec_bundle.alu_op    = 2'b10;
                    dec_bundle.alu_src   = 1'b1;
                    dec_bundle.reg_write = 1'b1;
                    case (instr_opcode)
                        OP_ANDI: dec_bundle.opcode = NB_OPCODE'(6'b100100);
                        OP_ORI:  dec_bundle.opcode = NB_OPCODE'(6'b100101);
                        OP_XORI: dec_bundle.opcode = NB_OPCODE'(6'b100110);
                        OP_SLTI: dec_bundle.opcode = NB_OPCODE'(6'b101010);
                        OP_LUI:  dec_bundle.opcode = NB_OPCODE'(6'b001111);
                        default: dec_bundle.opcode = NB_OPCODE'(6'b001000);
                    endcase
                end
                OP_BEQ, OP_BNE: begin
                    dec_bundle.valid  = 1'b1;
                    dec_bundle.branch = 1'b1;
                    dec_bundle.alu_op = 2'b01;
                    dec_bundle.opcode = (instr_opcode == OP_BEQ) ? NB_OPCODE'(6'b100011)
                                                                 : NB_OPCODE'(6'b100010);
                end
                OP_J: begin
                    dec_bundle.valid  = 1'b1;
                    dec_bundle.jump   = 2'b01;
                    dec_bundle.flush  = 1'b1;
                    dec_bundle.opcode = OP_J;
                end
                OP_JAL: begin
                    dec_bundle.valid     = 1'b1;
                    dec_bundle.reg_dst   = 1'b1;
                    dec_bundle.reg_write = 1'b1;
                    dec_bundle.jump      = 2'b01;
                    dec_bundle.flush     = 1'b1;
                    dec_bundle.opcode    = OP_JAL;
                end
                OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWU: begin
                    dec_bundle.valid      = 1'b1;
                    dec_bundle.mem_read   = 1'b1;
                    dec_bundle.mem_to_reg = 1'b1;
                    dec_bundle.alu_src    = 1'b1;
                    dec_bundle.reg_write  = 1'b1;
                    dec_bundle.opcode     = instr_opcode;
                end
                OP_SB, OP_SH, OP_SW: begin
                    dec_bundle.valid     = 1'b1;
                    dec_bundle.mem_write = 1'b1;
                    dec_bundle.alu_src   = 1'b1;
                    dec_bundle.opcode    = instr_opcode;
                end
                default: begin
                    dec_bundle.illegal = 1'b1;
                end
            endcase
        end
    end

    // Next-state: flush > stall > squash > accept; drain/halted force bubbles.
    always_comb begin
        state_next  = state_reg;
        bundle_next = bundle_reg;
        squash_next = squash_reg;
        drain_next  = drain_reg;
        halted_next = halted_reg;
        case (state_reg)
            ST_RUN: begin
                if (i_flush) begin
                    bundle_next = '0;
                    squash_next = 2'd0;
                end else if (i_stall) begin
                    bundle_next = bundle_reg;
                end else if (squash_reg != 2'd0) begin
                    bundle_next = '0;
                    if (i_valid) begin
                        squash_next = squash_reg - 2'd1;
                    end
                end else if (i_valid) begin
                    if (dec_halt) begin
                        bundle_next = '0;
                        state_next  = ST_DRAIN;
                        drain_next  = NB_DRAIN'(DRAIN_CYCLES - 1);
                    end else begin
                        bundle_next = dec_bundle;
                        if (dec_bundle.flush) begin
                            squash_next = 2'(N_SQUASH);
                        end
                    end
                end else begin
                    bundle_next = '0;
                end
            end
            ST_DRAIN: begin
                bundle_next = '0;
                if (!i_stall) begin
                    if (drain_reg == '0) begin
                        state_next  = ST_HALTED;
                        halted_next = 1'b1;
                    end else begin
                        drain_next = drain_reg - NB_DRAIN'(1);
                    end
                end
            end
            ST_HALTED: begin
                bundle_next = '0;
                halted_next = 1'b1;
            end
            default: begin
                state_next  = ST_RUN;
                bundle_next = '0;
            end
        endcase
    end

    // ID/EX register, FSM state and counters with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg  <= ST_RUN;
            bundle_reg <= '0;
            squash_reg <= 2'd0;
            drain_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bundle_reg <= bundle_next;
            squash_reg <= squash_next;
            drain_reg  <= drain_next;
            halted_reg <= halted_next;
        end
    end

    assign o_valid      = bundle_reg.valid;
    assign o_alu_op     = bundle_reg.alu_op;
    assign o_alu_src    = bundle_reg.alu_src;
    assign o_reg_dst    = bundle_reg.reg_dst;
    assign o_branch     = bundle_reg.branch;
    assign o_mem_read   = bundle_reg.mem_read;
    assign o_mem_write  = bundle_reg.mem_write;
    assign o_mem_to_reg = bundle_reg.mem_to_reg;
    assign o_reg_write  = bundle_reg.reg_write;
    assign o_jump       = bundle_reg.jump;
    assign o_flush      = bundle_reg.flush;
    assign o_opcode     = bundle_reg.opcode;
    assign o_illegal    = bundle_reg.illegal;
    assign o_halted     = halted_reg;

endmodule

// File: tb/tb_control_stage.sv
// Directed bench for control_stage: decode, squash, stall/flush, illegal and
// halt/drain behaviour with hand-computed expected bundles.
module tb_control_stage;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [31:0] i_instruction;
    logic        i_valid;
    logic        i_stall;
    logic        i_flush;
    logic        o_valid;
    logic [1:0]  o_alu_op;
    logic        o_alu_src;
    logic        o_reg_dst;
    logic        o_branch;
    logic        o_mem_read;
    logic        o_mem_write;
    logic        o_mem_to_reg;
    logic        o_reg_write;
    logic [1:0]  o_jump;
    logic        o_flush;
    logic [5:0]  o_opcode;
    logic        o_illegal;
    logic        o_halted;

    int n_vec = 0;
    int n_err = 0;

    control_stage #(
        .NB_DATA      (32),
        .NB_OPCODE    (6),
        .NB_FUNCTION  (6),
        .HALT_OPCODE  (6'b111111),
        .DRAIN_CYCLES (4),
        .N_SQUASH     (1)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_instruction (i_instruction),
        .i_valid       (i_valid),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .o_alu_op      (o_alu_op),
        .o_alu_src     (o_alu_src),
        .o_reg_dst     (o_reg_dst),
        .o_branch      (o_branch),
        .o_mem_read    (o_mem_read),
        .o_mem_write   (o_mem_write),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_reg_write   (o_reg_write),
        .o_jump        (o_jump),
        .o_flush       (o_flush),
        .o_opcode      (o_opcode),
        .o_illegal     (o_illegal),
        .o_halted      (o_halted)
    );

    always #5 i_clock = ~i_clock;

    // Packs expected fields in output-port order.
    function automatic logic [20:0] bnd(
        input logic v, input logic [1:0] aop, input logic asrc, input logic rdst,
        input logic br, input logic mr, input logic mw, input logic m2r,
        input logic rw, input logic [1:0] jmp, input logic fl,
        input logic [5:0] op, input logic ill, input logic hlt);
        return {v, aop, asrc, rdst, br, mr, mw, m2r, rw, jmp, fl, op, ill, hlt};
    endfunction

    localparam logic [20:0] BUBBLE  = 21'd0;
    localparam logic [20:0] HALTBUB = 21'd1;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [20:0] expected);
        logic [20:0] observed;
        observed = {o_valid, o_alu_op, o_alu_src, o_reg_dst, o_branch, o_mem_read,
                    o_mem_write, o_mem_to_reg, o_reg_write, o_jump, o_flush,
                    o_opcode, o_illegal, o_halted};
        n_vec++;
        assert (observed === expected) begin
            $display("vec %0d %-14s obs=%06h exp=%06h ok", n_vec, tag, observed, expected);
        end else begin
            n_err++;
            $error("FAIL %s: observed=%06h expected=%06h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic v, input logic st, input logic fl);
        i_instruction = instr;
        i_valid       = v;
        i_stall       = st;
        i_flush       = fl;
    endtask

    initial begin
        logic [20:0] e_addi, e_jal, e_add, e_lw, e_ill, e_andi, e_beq, e_jr, e_sw;
        e_addi = bnd(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b001000, 0, 0);
        e_jal  = bnd(1, 2'b00, 0, 1, 0, 0, 0, 0, 1, 2'b01, 1, 6'b000011, 0, 0);
        e_add  = bnd(1, 2'b10, 0, 1, 0, 0, 0, 0, 1, 2'b00, 0, 6'b100000, 0, 0);
        e_lw   = bnd(1, 2'b00, 1, 0, 0, 1, 0, 1, 1, 2'b00, 0, 6'b100011, 0, 0);
        e_ill  = bnd(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 6'b000000, 1, 0);
        e_andi = bnd(1, 2'b10, 1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 6'b100100, 0, 0);
        e_beq  = bnd(1, 2'b01, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 6'b100011, 0, 0);
        e_jr   = bnd(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 6'b001000, 0, 0);
        e_sw   = bnd(1, 2'b00, 1, 0, 0, 0, 1, 0, 0, 2'b00, 0, 6'b101011, 0, 0);

        // Reset with a valid instruction present: outputs stay zero.
        i_reset = 1'b1;
        drive(32'h20010005, 1, 0, 0);
        tick(); check("reset0", BUBBLE);
        tick(); check("reset1", BUBBLE);

        // addi decode, one-cycle latency.
        i_reset = 1'b0;
        tick(); check("addi", e_addi);

        // jal, then add squashed, then add decoded.
        drive(32'h0C000010, 1, 0, 0);
        tick(); check("jal", e_jal);
        drive(32'h00221820, 1, 0, 0);
        tick(); check("add_squashed", BUBBLE);
        tick(); check("add", e_add);

        // lw held through three stalls, then flushed.
        drive(32'h8C220004, 1, 0, 0);
        tick(); check("lw", e_lw);
        drive(32'h00221820, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick(); check("lw_stall", e_lw);
        end
        drive(32'h00221820, 1, 0, 1);
        tick(); check("lw_flush", BUBBLE);

        // Illegal opcode 011100: pulse held by one stall, then cleared.
        drive(32'h70000000, 1, 0, 0);
        tick(); check("illegal", e_ill);
        drive(32'h70000000, 1, 1, 0);
        tick(); check("illegal_hold", e_ill);
        drive(32'h00000000, 0, 0, 0);
        tick(); check("idle_bubble", BUBBLE);
        drive(32'h30220001, 1, 0, 0);
        tick(); check("andi", e_andi);

        // beq, then jr with an invalid slot (counter kept) before squash.
        drive(32'h10220003, 1, 0, 0);
        tick(); check("beq", e_beq);
        drive(32'h03E00008, 1, 0, 0);
        tick(); check("jr", e_jr);
        drive(32'h00000000, 0, 0, 0);
        tick(); check("jr_idle", BUBBLE);
        drive(32'h20010005, 1, 0, 0);
        tick(); check("jr_squash", BUBBLE);
        tick(); check("addi_after_jr", e_addi);

        // Halt with one stall during drain: o_halted 5 edges after acceptance.
        drive(32'hFC000000, 1, 0, 0);
        tick(); check("halt_accept", BUBBLE);
        drive(32'h00221820, 1, 0, 1);
        tick(); check("drain1", BUBBLE);
        drive(32'h00221820, 1, 1, 0);
        tick(); check("drain_stall", BUBBLE);
        drive(32'h00221820, 1, 0, 0);
        tick(); check("drain2", BUBBLE);
        tick(); check("drain3", BUBBLE);
        tick(); check("halted", HALTBUB);
        tick(); check("halted_add1", HALTBUB);
        tick(); check("halted_add2", HALTBUB);

        // Reset leaves HALTED.
        i_reset = 1'b1;
        tick(); check("reset_halted", BUBBLE);
        i_reset = 1'b0;

        // Reset during drain, then sw decodes normally.
        drive(32'hFC000000, 1, 0, 0);
        tick(); check("halt2_accept", BUBBLE);
        drive(32'h00000000, 0, 0, 0);
        tick(); check("halt2_drain", BUBBLE);
        i_reset = 1'b1;
        tick(); check("reset_drain", BUBBLE);
        i_reset = 1'b0;
        drive(32'hAC220000, 1, 0, 0);
        tick(); check("sw", e_sw);
        drive(32'h00000000, 0, 0, 0);
        tick(); check("final_idle", BUBBLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
